lectura_rtc: RTL and testbench

- Read sequencer for the RTC register bus; it is the counterpart of the RTC write sequencer.
- On request it issues two transactions to the bus controller:
  - a transfer command that latches the RTC counters into the readable registers;
  - a read of register `dir`.
- It captures the returned byte and pulses `final`.
- It sits between the clock/date control FSM and the shared RTC bus controller, which acknowledges each transaction with `fin`.

---
 rtl/lectura_rtc_if.sv | 13 +
 rtl/lectura_rtc.sv | 92 +++++++++
 tb/tb_lectura_rtc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lectura_rtc_if.sv
// lectura_rtc_if: transaction bus between the RTC read sequencer (master)
// and the shared RTC bus controller (slave).
interface lectura_rtc_if;
    logic [7:0] dir_out;
    logic [7:0] data_out;
    logic [7:0] dato_in;
    logic       escribe;
    logic       lee;
    logic       activa;
    logic       fin;
    modport master(output dir_out, data_out, escribe, lee, activa, input fin, dato_in);
    modport slave(input dir_out, data_out, escribe, lee, activa, output fin, dato_in);
endinterface

// File: rtl/lectura_rtc.sv
// lectura_rtc: RTC read sequencer (transfer command, gap, register read, done pulse).
// Optional macro LECTURA_BCD_CHECK_EN flags non-BCD read data as an error.
module lectura_rtc #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [7:0] dir,
    lectura_rtc_if.master bus,
    output logic [7:0] dato_leido,
    output logic       final_lectura,
    output logic       error
);
    typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;
    state_t           state;
    logic             armed;
    logic [7:0]       dir_q;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic             bcd_bad;
    logic [7:0]       cmd;
    assign timeout = cnt == CNT_W'(TIMEOUT_CYC) && !bus.fin;
    assign cmd     = (dir inside {8'h41, 8'h42, 8'h43}) ? 8'hF3 : 8'hF1;
`ifdef LECTURA_BCD_CHECK_EN
    assign bcd_bad = bus.dato_in[7:4] > 4'd9 || bus.dato_in[3:0] > 4'd9;
`else
    assign bcd_bad = 1'b0;
`endif
    // Outputs are set alongside the state they belong to, so they stay pure Moore.
    always_ff @(posedge clk) begin
        if (reset || (!iniciar && state != IDLE)) begin
            state         <= IDLE;
            armed         <= 1'b0;
            dir_q         <= '0;
            cnt           <= '0;
            bus.dir_out   <= '0;
            bus.data_out  <= '0;
            bus.escribe   <= 1'b0;
            bus.lee       <= 1'b0;
            bus.activa    <= 1'b0;
            final_lectura <= 1'b0;
            error         <= 1'b0;
            if (reset) dato_leido <= '0;
        end else begin
            cnt           <= cnt + 1'b1;
            final_lectura <= 1'b0;
            error         <= 1'b0;
            case (state)
                IDLE: begin
                    if (!iniciar) armed <= 1'b1;
                    else if (armed) begin
                        armed        <= 1'b0;
                        dir_q        <= dir;
                        cnt          <= '0;
                        state        <= CMD;
                        bus.escribe  <= 1'b1;
                        bus.activa   <= 1'b1;
                        bus.dir_out  <= cmd;
                        bus.data_out <= cmd;
                    end
                end
                CMD: if (bus.fin || timeout) begin
                    state         <= bus.fin ? GAP : DONE;
                    bus.escribe   <= 1'b0;
                    bus.activa    <= bus.fin;
                    bus.dir_out   <= '0;
                    bus.data_out  <= '0;
                    final_lectura <= !bus.fin;
                    error         <= !bus.fin;
                end
                GAP: begin
                    state       <= READ;
                    cnt         <= '0;
                    bus.lee     <= 1'b1;
                    bus.dir_out <= dir_q;
                end
                READ: if (bus.fin || timeout) begin
                    state         <= DONE;
                    bus.lee       <= 1'b0;
                    bus.activa    <= 1'b0;
                    bus.dir_out   <= '0;
                    final_lectura <= 1'b1;
                    error         <= !bus.fin || bcd_bad;
                    dato_leido    <= bus.fin ? bus.dato_in : dato_leido;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lectura_rtc.sv
// tb_lectura_rtc: randomized read requests checked cycle by cycle against an
// expected trace built from the request's timing parameters.
module tb_lectura_rtc;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [7:0] dir = 8'h00;
    logic [7:0] dato_leido;
    logic       final_lectura;
    logic       error;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] dl_m = 8'h00;
    logic [7:0] cur_dir = 8'h00;

    typedef struct packed {
        logic       ini;
        logic       fin;
        logic [7:0] din;
        logic       esc;
        logic       lee;
        logic       act;
        logic [7:0] dout;
        logic [7:0] ddat;
        logic       fo;
        logic       er;
        logic [7:0] dl;
    } cyc_t;
    cyc_t q[$];

    lectura_rtc_if bus();

    lectura_rtc #(.TIMEOUT_CYC(15), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .iniciar(iniciar),
        .dir(dir),
        .bus(bus.master),
        .dato_leido(dato_leido),
        .final_lectura(final_lectura),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] obs();
        return {bus.escribe, bus.lee, bus.activa, bus.dir_out, bus.data_out,
                final_lectura, error, dato_leido};
    endfunction

    function automatic logic bcd_bad(input logic [7:0] v);
`ifdef LECTURA_BCD_CHECK_EN
        return (v / 16) > 9 || (v % 16) > 9;
`else
        return v != v;
`endif
    endfunction

    task automatic add(input logic ini, input logic fin, input logic [7:0] din,
                       input logic esc, input logic lee, input logic act,
                       input logic [7:0] dout, input logic [7:0] ddat,
                       input logic fo, input logic er);
        q.push_back('{ini, fin, din, esc, lee, act, dout, ddat, fo, er, dl_m});
    endtask

    task automatic play(input string name);
        foreach (q[i]) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", name, i), obs(),
                  {q[i].esc, q[i].lee, q[i].act, q[i].dout, q[i].ddat, q[i].fo, q[i].er, q[i].dl});
            iniciar     = q[i].ini;
            bus.fin     = q[i].fin;
            bus.dato_in = q[i].din;
            dir         = (i == 0) ? cur_dir : 8'($urandom);
        end
    endtask

    // cl/rl: cycles of waiting before fin in CMD/READ; >=16 means fin never comes.
    task automatic request(input string name, input logic [7:0] d, input int cl, input int rl,
                           input logic [7:0] dv, input int ab, input logic abfin, input int hold);
        logic [7:0] c;
        logic       to;
        int         n;
        q.delete();
        cur_dir = d;
        c = (d >= 8'h41 && d <= 8'h43) ? 8'hF3 : 8'hF1;
        add(1, 1'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 0, 0);
        to = cl >= 16;
        n = to ? 16 : cl + 1;
        for (int i = 0; i < n; i++) add(1, !to && i == cl, 8'($urandom), 1, 0, 1, c, c, 0, 0);
        if (to) add(1, 1'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 1, 1);
        else begin
            add(1, 1'($urandom), 8'($urandom), 0, 0, 1, 0, 0, 0, 0);
            to = rl >= 16;
            n = to ? 16 : rl + 1;
            for (int i = 0; i < n; i++)
                add(1, !to && i == rl, (i == rl) ? dv : 8'($urandom), 0, 1, 1, d, 0, 0, 0);
            if (!to) dl_m = dv;
            add(1, 1'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 1, to || bcd_bad(dv));
        end
        for (int i = 0; i < hold; i++) add(1, 1'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 0, 0);
        if (ab > 0 && ab < q.size()) begin
            q[ab].ini = 1'b0;
            if (abfin) q[ab].fin = 1'b1;
            while (q.size() > ab + 1) q.pop_back();
        end
        dl_m = q[q.size()-1].dl;
        add(0, 1'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 0, 0);
        play(name);
    endtask

    initial begin
        bus.fin     = 1'b0;
        bus.dato_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("reset", obs(), '0);
        reset   = 1'b0;
        iniciar = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        play("unarmed");
        request("normal",   8'h21, 1,  0,  8'h45, 0, 0, 3);
        request("timer",    8'h42, 0,  0,  8'h12, 0, 0, 1);
        request("rd_to",    8'h10, 0,  16, 8'h77, 0, 0, 2);
        request("abort",    8'h30, 0,  5,  8'h66, 4, 1, 0);
        request("rearm",    8'h41, 2,  1,  8'h08, 0, 0, 20);
        request("cmd_to",   8'h43, 16, 0,  8'h11, 0, 0, 2);
        request("cmd_edge", 8'h44, 15, 0,  8'h23, 0, 0, 1);
        request("rd_edge",  8'h40, 0,  15, 8'h98, 0, 0, 1);
        request("bcd_bad",  8'h05, 0,  0,  8'h5A, 0, 0, 1);
        request("bcd_ok",   8'h06, 0,  0,  8'h59, 0, 0, 1);
        for (int k = 0; k < 40; k++) begin
            logic [7:0] d;
            int         cl;
            int         rl;
            d  = ($urandom_range(0, 2) == 0) ? 8'(8'h40 + $urandom_range(0, 4)) : 8'($urandom);
            cl = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            rl = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            request($sformatf("rnd%0d", k), d, cl, rl, 8'($urandom),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0,
                    1'($urandom), $urandom_range(0, 5));
        end
        @(negedge clk);
        iniciar = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid", obs(), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
